// File: rtl/lane_merge_arbiter.sv
// Merges two lane byte streams through per-lane FIFOs using a round-robin arbiter.
// Optional LANE_IDLE_FILTER_EN drops IDLE symbols before they reach the FIFOs.
module lane_merge_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter logic [7:0]  IDLE  = 8'h7C
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic [7:0] data_outser0,
   input  logic       valid_outser0,
   input  logic [7:0] data_outser1,
   input  logic       valid_outser1,
   input  logic       flush,
   input  logic       out_ready,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active_out,
   output logic       fifo_full0,
   output logic       fifo_full1,
   output logic       overflow0,
   output logic       overflow1
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef LANE_IDLE_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   typedef enum logic {ST_INIT = 1'b0, ST_ACTIVE = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem0_q [DEPTH];
   logic [7:0]      mem1_q [DEPTH];
   logic [AW-1:0]   wr0_ptr_q, rd0_ptr_q, wr1_ptr_q, rd1_ptr_q;
   logic [CW-1:0]   count0_q, count1_q, count0_d, count1_d;
   logic            last_grant_q;
   logic [7:0]      data_q;
   logic            valid_q, full0_q, full1_q, ovf0_q, ovf1_q;
   logic            pop0_c, pop1_c;
   logic            in0_c, in1_c, wr0_c, wr1_c;
   logic            clear_c;

   assign clear_c = !reset_L || flush;

   always_ff @(posedge clk) begin
      if (clear_c) state_q <= ST_INIT;
      else         state_q <= state_d;
   end

   // Leave INIT once both lanes hold data as seen before this edge's writes.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && count0_q != '0 && count1_q != '0)
         state_d = ST_ACTIVE;
   end

   // Round-robin pop decision; preferred lane is the one not granted last.
   always_comb begin
      pop0_c = 1'b0;
      pop1_c = 1'b0;
      if (state_q == ST_ACTIVE && out_ready) begin
         if (last_grant_q) begin
            if (count0_q != '0)      pop0_c = 1'b1;
            else if (count1_q != '0) pop1_c = 1'b1;
         end else begin
            if (count1_q != '0)      pop1_c = 1'b1;
            else if (count0_q != '0) pop0_c = 1'b1;
         end
      end
   end

   assign in0_c    = valid_outser0 && !(FILTER_EN && data_outser0 == IDLE);
   assign in1_c    = valid_outser1 && !(FILTER_EN && data_outser1 == IDLE);
   assign wr0_c    = in0_c && (count0_q != CW'(DEPTH) || pop0_c);
   assign wr1_c    = in1_c && (count1_q != CW'(DEPTH) || pop1_c);
   assign count0_d = count0_q + CW'(wr0_c) - CW'(pop0_c);
   assign count1_d = count1_q + CW'(wr1_c) - CW'(pop1_c);

   always_ff @(posedge clk) begin
      if (!clear_c && wr0_c) mem0_q[wr0_ptr_q] <= data_outser0;
      if (!clear_c && wr1_c) mem1_q[wr1_ptr_q] <= data_outser1;
   end

   always_ff @(posedge clk) begin
      if (clear_c) begin
         wr0_ptr_q    <= '0;
         rd0_ptr_q    <= '0;
         wr1_ptr_q    <= '0;
         rd1_ptr_q    <= '0;
         count0_q     <= '0;
         count1_q     <= '0;
         last_grant_q <= 1'b1;
         data_q       <= 8'h00;
         valid_q      <= 1'b0;
         full0_q      <= 1'b0;
         full1_q      <= 1'b0;
         ovf0_q       <= 1'b0;
         ovf1_q       <= 1'b0;
      end else begin
         if (wr0_c)  wr0_ptr_q <= wr0_ptr_q + AW'(1);
         if (wr1_c)  wr1_ptr_q <= wr1_ptr_q + AW'(1);
         if (pop0_c) rd0_ptr_q <= rd0_ptr_q + AW'(1);
         if (pop1_c) rd1_ptr_q <= rd1_ptr_q + AW'(1);
         count0_q <= count0_d;
         count1_q <= count1_d;
         full0_q  <= (count0_d == CW'(DEPTH));
         full1_q  <= (count1_d == CW'(DEPTH));
         if (in0_c && !wr0_c) ovf0_q <= 1'b1;
         if (in1_c && !wr1_c) ovf1_q <= 1'b1;
         valid_q  <= pop0_c || pop1_c;
         if (pop0_c) begin
            data_q       <= mem0_q[rd0_ptr_q];
            last_grant_q <= 1'b0;
         end else if (pop1_c) begin
            data_q       <= mem1_q[rd1_ptr_q];
            last_grant_q <= 1'b1;
         end
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign active_out = (state_q == ST_ACTIVE);
   assign fifo_full0 = full0_q;
   assign fifo_full1 = full1_q;
   assign overflow0  = ovf0_q;
   assign overflow1  = ovf1_q;

endmodule

// File: tb/tb_lane_merge_arbiter.sv
// Bench for lane_merge_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_lane_merge_arbiter;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_L, flush, out_ready;
   logic [7:0] data_outser0, data_outser1;
   logic       valid_outser0, valid_outser1;
   logic [7:0] data_out;
   logic       valid_out, active_out, fifo_full0, fifo_full1, overflow0, overflow1;

   int n_total = 0;
   int n_bad   = 0;

   bit [7:0] mq0[$];
   bit [7:0] mq1[$];
   bit       m_act, m_lg, m_ov0, m_ov1, m_v;
   bit [7:0] m_d;
   bit [7:0] cap[$];

   lane_merge_arbiter #(.DEPTH(DEPTH), .IDLE(8'h7C)) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .data_outser0  (data_outser0),
      .valid_outser0 (valid_outser0),
      .data_outser1  (data_outser1),
      .valid_outser1 (valid_outser1),
      .flush         (flush),
      .out_ready     (out_ready),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .active_out    (active_out),
      .fifo_full0    (fifo_full0),
      .fifo_full1    (fifo_full1),
      .overflow0     (overflow0),
      .overflow1     (overflow1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_idle(input bit [7:0] d);
`ifdef LANE_IDLE_FILTER_EN
      return d == 8'h7C;
`else
      return 1'b0;
`endif
   endfunction

   // Reference behaviour for one rising edge, working on byte queues.
   task automatic model_edge(input bit v0, input bit [7:0] d0, input bit v1, input bit [7:0] d1,
                             input bit rdy, input bit fl, input bit rst_n);
      int pl;
      bit go;
      if (!rst_n || fl) begin
         mq0.delete(); mq1.delete();
         m_act = 0; m_lg = 1; m_ov0 = 0; m_ov1 = 0; m_v = 0; m_d = 8'h00;
         return;
      end
      pl = -1;
      if (m_act && rdy) begin
         if (m_lg) pl = (mq0.size() > 0) ? 0 : (mq1.size() > 0) ? 1 : -1;
         else      pl = (mq1.size() > 0) ? 1 : (mq0.size() > 0) ? 0 : -1;
      end
      go  = !m_act && mq0.size() > 0 && mq1.size() > 0;
      m_v = (pl >= 0);
      if (pl == 0) begin m_d = mq0.pop_front(); m_lg = 0; end
      else if (pl == 1) begin m_d = mq1.pop_front(); m_lg = 1; end
      if (v0 && !is_idle(d0)) begin
         if (mq0.size() < DEPTH) mq0.push_back(d0); else m_ov0 = 1;
      end
      if (v1 && !is_idle(d1)) begin
         if (mq1.size() < DEPTH) mq1.push_back(d1); else m_ov1 = 1;
      end
      if (go) m_act = 1;
   endtask

   task automatic step(input bit v0, input bit [7:0] d0, input bit v1, input bit [7:0] d1,
                       input bit rdy, input bit fl, input bit rst_n);
      valid_outser0 = v0; data_outser0 = d0;
      valid_outser1 = v1; data_outser1 = d1;
      out_ready = rdy; flush = fl; reset_L = rst_n;
      @(posedge clk);
      model_edge(v0, d0, v1, d1, rdy, fl, rst_n);
      #1;
      chk("valid_out", 32'(valid_out), 32'(m_v));
      chk("data_out", 32'(data_out), 32'(m_d));
      chk("active_out", 32'(active_out), 32'(m_act));
      chk("fifo_full0", 32'(fifo_full0), 32'(mq0.size() == DEPTH));
      chk("fifo_full1", 32'(fifo_full1), 32'(mq1.size() == DEPTH));
      chk("overflow0", 32'(overflow0), 32'(m_ov0));
      chk("overflow1", 32'(overflow1), 32'(m_ov1));
      if (valid_out) cap.push_back(data_out);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, rdy, 0, 1);
   endtask

   task automatic check_cap(input string tag, input bit [7:0] exp[$]);
      chk({tag, "_len"}, 32'(cap.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         chk(tag, (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
   endtask

   initial begin
      bit [7:0] exp[$];
      step(1, 8'h5A, 0, 8'h00, 1, 0, 0);

      // Reset hold with lane0 active; nothing may be stored.
      step(1, 8'h5A, 0, 8'h00, 1, 0, 0);
      step(1, 8'h5A, 0, 8'h00, 1, 0, 0);
      chk("rst_dout", 32'(data_out), 32'h0);
      step(0, 8'h00, 1, 8'hB0, 1, 0, 1);
      idle(3, 1);
      chk("rst_nostore_act", 32'(active_out), 32'h0);

      // Interleave
      step(0, 8'h00, 0, 8'h00, 1, 0, 0);
      cap.delete();
      step(1, 8'h11, 1, 8'hA1, 1, 0, 1);
      step(1, 8'h22, 1, 8'hA2, 1, 0, 1);
      chk("il_act", 32'(active_out), 32'h1);
      chk("il_novalid", 32'(valid_out), 32'h0);
      idle(4, 1);
      exp = '{8'h11, 8'hA1, 8'h22, 8'hA2};
      check_cap("interleave", exp);
      idle(2, 1);

      // Single-lane drain while ACTIVE
      cap.delete();
      step(1, 8'h30, 0, 8'h00, 1, 0, 1);
      step(1, 8'h31, 0, 8'h00, 1, 0, 1);
      step(1, 8'h32, 0, 8'h00, 1, 0, 1);
      idle(3, 1);
      exp = '{8'h30, 8'h31, 8'h32};
      check_cap("drain", exp);

      // Overflow on lane1 with consumer stalled
      step(0, 8'h00, 0, 8'h00, 1, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         step(0, 8'h00, 1, 8'(i), 0, 0, 1);
         if (i == 4) chk("ovf_full1", 32'(fifo_full1), 32'h1);
         if (i == 4) chk("ovf_not_yet", 32'(overflow1), 32'h0);
         if (i == 5) chk("ovf_set", 32'(overflow1), 32'h1);
      end
      cap.delete();
      step(1, 8'h99, 0, 8'h00, 1, 0, 1);
      idle(8, 1);
      exp = '{8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
      check_cap("overflow", exp);
      chk("ovf_sticky", 32'(overflow1), 32'h1);

      // Flush mid-stream
      step(1, 8'h41, 1, 8'h51, 0, 0, 1);
      step(1, 8'h42, 1, 8'h52, 0, 0, 1);
      step(1, 8'h43, 0, 8'h00, 0, 1, 1);
      chk("fl_act", 32'(active_out), 32'h0);
      chk("fl_ovf", 32'(overflow1), 32'h0);
      step(1, 8'h44, 0, 8'h00, 1, 0, 1);
      idle(3, 1);
      chk("fl_stay_init", 32'(active_out), 32'h0);

      // IDLE symbol handling
      step(0, 8'h00, 0, 8'h00, 1, 0, 0);
      cap.delete();
      step(1, 8'h7C, 1, 8'h66, 1, 0, 1);
      step(1, 8'h55, 0, 8'h00, 1, 0, 1);
      idle(5, 1);
`ifdef LANE_IDLE_FILTER_EN
      exp = '{8'h55, 8'h66};
`else
      exp = '{8'h7C, 8'h66, 8'h55};
`endif
      check_cap("filter", exp);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit [7:0] d0, d1;
         d0 = ($urandom_range(0, 7) == 0) ? 8'h7C : 8'($urandom);
         d1 = ($urandom_range(0, 7) == 0) ? 8'h7C : 8'($urandom);
         step(1'($urandom_range(0, 1)), d0, 1'($urandom_range(0, 1)), d1,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) == 0),
              1'($urandom_range(0, 299) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
